// File: rtl/extinguisher.sv
// extinguisher: snuffer arm controller that seeks to a candle slot, fires a fixed pulse, then cools down.
// Ports:
//   sys_clk    - system clock, rising-edge active
//   clr_n      - asynchronous active-low clear
//   enable     - level-sensitive request to snuff the candle at position
//   position   - target candle slot 0-7
//   extinguish - registered snuffer fire strobe
module extinguisher #(
  parameter int STEP_CYCLES     = 4,
  parameter int PULSE_CYCLES    = 4,
  parameter int COOLDOWN_CYCLES = 8
) (
  input  logic       sys_clk,
  input  logic       clr_n,
  input  logic       enable,
  input  logic [2:0] position,
  output logic       extinguish
);
  localparam int MAX_SP = STEP_CYCLES > PULSE_CYCLES ? STEP_CYCLES : PULSE_CYCLES;
  localparam int MAXP   = MAX_SP > COOLDOWN_CYCLES ? MAX_SP : COOLDOWN_CYCLES;
  localparam int CW     = MAXP > 1 ? $clog2(MAXP) : 1;
  typedef enum logic [1:0] {IDLE, SEEK, FIRE, COOLDOWN} state_t;
  state_t state, state_d;
  logic [2:0] ptr, ptr_d, target, target_d, ptr_step;
  logic [CW-1:0] cnt, cnt_d;
  logic ext_d, step_done, pulse_done, cool_done;
  // One shared counter serves all timed states; it restarts on every state change.
  assign step_done  = cnt == CW'(STEP_CYCLES - 1);
  assign pulse_done = cnt == CW'(PULSE_CYCLES - 1);
  assign cool_done  = cnt == CW'(COOLDOWN_CYCLES - 1);
  // Direct path only: target is never equal to ptr while seeking, so this never wraps.
  assign ptr_step   = target > ptr ? ptr + 3'd1 : ptr - 3'd1;
  always_ff @(posedge sys_clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= IDLE;
      ptr        <= 3'd0;
      target     <= 3'd0;
      cnt        <= '0;
      extinguish <= 1'b0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      target     <= target_d;
      cnt        <= cnt_d;
      extinguish <= ext_d;
    end
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     state_d = !enable ? IDLE : (position == ptr ? FIRE : SEEK);
      // Abort wins over a coincident arm step.
      SEEK:     state_d = !enable ? IDLE : (step_done && ptr_step == target ? FIRE : SEEK);
      FIRE:     state_d = pulse_done ? COOLDOWN : FIRE;
      COOLDOWN: state_d = cool_done ? IDLE : COOLDOWN;
      default:  state_d = IDLE;
    endcase
  end
  always_comb begin
    target_d = state == IDLE && enable ? position : target;
    ptr_d    = state == SEEK && enable && step_done ? ptr_step : ptr;
    cnt_d    = state_d != state || state == IDLE || (state == SEEK && step_done) ? '0 : cnt + CW'(1);
    ext_d    = state_d == FIRE;
  end
endmodule

// File: tb/tb_extinguisher.sv
// tb_extinguisher: directed table-driven bench for the extinguisher snuffer controller.
module tb_extinguisher;
  logic sys_clk = 1'b0;
  logic clr_n = 1'b0;
  logic enable = 1'b0;
  logic [2:0] position = 3'd0;
  logic extinguish;
  int cmp = 0;
  int errs = 0;
  typedef struct {
    logic [2:0] pos;
    int         lat;
    logic [2:0] ptr;
  } vec_t;
  vec_t tbl[7];
  extinguisher dut (
    .sys_clk(sys_clk),
    .clr_n(clr_n),
    .enable(enable),
    .position(position),
    .extinguish(extinguish)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge sys_clk);
    clr_n = 1'b0;
    enable = 1'b0;
    @(negedge sys_clk);
    clr_n = 1'b1;
    tick();
  endtask
  // Request pos, measure accept-to-fire latency, pulse width, and check no refire afterwards.
  task automatic do_seek(input logic [2:0] pos, input int exp_lat, input logic [2:0] exp_ptr);
    int lat;
    int w;
    logic refire;
    position = pos;
    enable = 1'b1;
    tick();
    lat = 0;
    while (!extinguish && lat < 200) begin
      tick();
      lat++;
    end
    check("latency", lat, exp_lat);
    check("ptr_at_fire", dut.ptr, exp_ptr);
    w = 1;
    tick();
    enable = 1'b0;
    while (extinguish && w < 20) begin
      w++;
      tick();
    end
    if (w == 1) w = 1;
    check("pulse_width", w, 4);
    refire = 1'b0;
    repeat (12) begin
      tick();
      if (extinguish) refire = 1'b1;
    end
    check("no_refire", refire, 0);
    check("idle_after", dut.state, 0);
  endtask
  initial begin
    logic [19:0] train, exp_train;
    logic seen;
    tbl[0] = '{3'd0, 0, 3'd0};
    tbl[1] = '{3'd5, 20, 3'd5};
    tbl[2] = '{3'd2, 12, 3'd2};
    tbl[3] = '{3'd7, 20, 3'd7};
    tbl[4] = '{3'd7, 0, 3'd7};
    tbl[5] = '{3'd0, 28, 3'd0};
    tbl[6] = '{3'd1, 4, 3'd1};
    #12;
    check("rst_ext", extinguish, 0);
    check("rst_ptr", dut.ptr, 0);
    check("rst_state", dut.state, 0);
    #8;
    clr_n = 1'b1;
    tick();
    // Continuous enable at the current slot: 4 high, 9 low, 4 high.
    exp_train = 20'b0;
    for (int i = 0; i < 20; i++) exp_train[i] = (i < 4) || (i >= 13 && i < 17);
    position = 3'd0;
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      train[i] = extinguish;
    end
    check("pulse_train", train, exp_train);
    enable = 1'b0;
    repeat (10) tick();
    check("train_idle", dut.state, 0);
    for (int i = 0; i < 7; i++) do_seek(tbl[i].pos, tbl[i].lat, tbl[i].ptr);
    // Abort mid-seek after one arm step; a position change must not touch the latched target.
    do_reset();
    position = 3'd7;
    enable = 1'b1;
    tick();
    position = 3'd3;
    tick();
    check("target_latched", dut.target, 7);
    repeat (4) tick();
    enable = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (extinguish) seen = 1'b1;
    end
    check("abort_no_fire", seen, 0);
    check("abort_state", dut.state, 0);
    check("abort_ptr", dut.ptr, 1);
    // Asynchronous clear while the pulse is high.
    position = 3'd1;
    enable = 1'b1;
    tick();
    check("mid_fire_ext", extinguish, 1);
    tick();
    #2;
    clr_n = 1'b0;
    #1;
    check("async_clr_ext", extinguish, 0);
    check("async_clr_ptr", dut.ptr, 0);
    check("async_clr_state", dut.state, 0);
    enable = 1'b0;
    @(negedge sys_clk);
    clr_n = 1'b1;
    tick();
    do_seek(3'd3, 12, 3'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
